nco_sequencer: RTL and testbench

NCO_SEQUENCER -- requirements
Module: nco_sequencer

---
 rtl/nco_pkg.sv | 26 ++
 rtl/nco_tick_gen.sv | 36 +++
 rtl/nco_sequencer.sv | 161 ++++++++++++++++
 tb/tb_nco_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared types for the NCO program sequencer: wave codes, FSM encoding and
// the sample-tick divider calculation.
package nco_pkg;

    typedef enum logic [1:0] {
        WAVE_SINE     = 2'd0,
        WAVE_TRIANGLE = 2'd1,
        WAVE_SAWTOOTH = 2'd2,
        WAVE_SQUARE   = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Clocks per sample tick, never less than one.
    function automatic int calc_div(input int clk_freq, input int sample_rate);
        int d;
        d = clk_freq / sample_rate;
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/nco_tick_gen.sv
// Sample-tick divider: down-counter reloaded on restart, tick at terminal count.
module nco_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    input  logic run_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = RELOAD;
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = run_i && !restart_i && (cnt_q == '0);

endmodule

// File: rtl/nco_sequencer.sv
// Steps an NCO through a programmed table of frequency/wave/duty entries,
// each held for a given number of sample ticks.
//   state | meaning
//   IDLE  | waiting for start, enable low
//   LOAD  | one cycle: latch entry[step_idx], reload remaining and divider
//   PLAY  | count sample ticks down, advance when the step expires
//   DONE  | one cycle done pulse, then IDLE
module nco_sequencer
    import nco_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int BIT_DEPTH   = 16,
    parameter int STEPS       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [63:0]              wr_freq,
    input  logic [1:0]               wr_wave,
    input  logic [BIT_DEPTH-1:0]     wr_duty,
    input  logic [15:0]              wr_len,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output logic [63:0]              frequency,
    output logic [1:0]               wave,
    output logic [BIT_DEPTH-1:0]     duty_cycle,
    output logic                     enable,
    output logic                     busy,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     done
);

    localparam int DIV = calc_div(CLK_FREQ, SAMPLE_RATE);
    localparam int AW  = $clog2(STEPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(STEPS - 1);

    logic [63:0]          freq_tbl_q [STEPS];
    logic [1:0]           wave_tbl_q [STEPS];
    logic [BIT_DEPTH-1:0] duty_tbl_q [STEPS];
    logic [15:0]          len_tbl_q  [STEPS];

    state_e               state_q;
    logic [63:0]          frequency_q;
    logic [1:0]           wave_q;
    logic [BIT_DEPTH-1:0] duty_q;
    logic                 enable_q;
    logic                 busy_q;
    logic [AW-1:0]        step_idx_q;
    logic                 done_q;
    logic [15:0]          remaining_q;

    logic                 tick_restart;
    logic                 tick_run;
    logic                 tick;
    logic [15:0]          cur_len;

    // Table has no reset; a LOAD in the same cycle as a write sees the old entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            freq_tbl_q[wr_addr] <= wr_freq;
            wave_tbl_q[wr_addr] <= wr_wave;
            duty_tbl_q[wr_addr] <= wr_duty;
            len_tbl_q[wr_addr]  <= wr_len;
        end
    end

    assign cur_len      = len_tbl_q[step_idx_q];
    assign tick_restart = (state_q == ST_LOAD);
    assign tick_run     = (state_q == ST_PLAY);

    nco_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (tick_restart),
        .run_i     (tick_run),
        .tick_o    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            frequency_q <= '0;
            wave_q      <= '0;
            duty_q      <= '0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            step_idx_q  <= '0;
            done_q      <= 1'b0;
            remaining_q <= '0;
        end else if (stop) begin
            state_q  <= ST_IDLE;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        step_idx_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    frequency_q <= freq_tbl_q[step_idx_q];
                    wave_q      <= wave_tbl_q[step_idx_q];
                    duty_q      <= duty_tbl_q[step_idx_q];
                    remaining_q <= cur_len;
                    if (cur_len != 16'd0) begin
                        enable_q <= 1'b1;
                        state_q  <= ST_PLAY;
                    end else if (loop && step_idx_q != '0) begin
                        step_idx_q <= '0;
                    end else begin
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        remaining_q <= remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            if (step_idx_q != LAST_IDX) begin
                                step_idx_q <= step_idx_q + 1'b1;
                                state_q    <= ST_LOAD;
                            end else if (loop) begin
                                step_idx_q <= '0;
                                state_q    <= ST_LOAD;
                            end else begin
                                enable_q <= 1'b0;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                state_q  <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign frequency  = frequency_q;
    assign wave       = wave_q;
    assign duty_cycle = duty_q;
    assign enable     = enable_q;
    assign busy       = busy_q;
    assign step_idx   = step_idx_q;
    assign done       = done_q;

endmodule

// File: tb/tb_nco_sequencer.sv
// Directed bench for nco_sequencer with DIV=4 and an 8-entry table.
module tb_nco_sequencer;
    import nco_pkg::*;

    localparam logic [63:0] F1000 = 64'h0000_03E8_0000_0000;
    localparam logic [63:0] F2000 = 64'h0000_07D0_0000_0000;
    localparam logic [63:0] F3000 = 64'h0000_0BB8_0000_0000;
    localparam logic [63:0] F5000 = 64'h0000_1388_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [63:0] wr_freq = '0;
    logic [1:0]  wr_wave = '0;
    logic [15:0] wr_duty = '0;
    logic [15:0] wr_len = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [63:0] frequency;
    logic [1:0]  wave;
    logic [15:0] duty_cycle;
    logic        enable;
    logic        busy;
    logic [2:0]  step_idx;
    logic        done;

    int total = 0;
    int bad = 0;

    nco_sequencer #(
        .CLK_FREQ    (192000),
        .SAMPLE_RATE (48000),
        .BIT_DEPTH   (16),
        .STEPS       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_freq    (wr_freq),
        .wr_wave    (wr_wave),
        .wr_duty    (wr_duty),
        .wr_len     (wr_len),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .frequency  (frequency),
        .wave       (wave),
        .duty_cycle (duty_cycle),
        .enable     (enable),
        .busy       (busy),
        .step_idx   (step_idx),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [63:0] f, input logic [1:0] w,
                      input logic [15:0] d, input logic [15:0] l);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_freq = f;
        wr_wave = w;
        wr_duty = d;
        wr_len  = l;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        int en_lo;
        int done_cnt;
        int nseq;
        logic [2:0] seq [8];
        logic [2:0] last_idx;

        // Reset values
        step();
        step();
        chk("rst_enable", 64'(enable), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_freq", frequency, 64'd0);
        chk("rst_idx", 64'(step_idx), 64'd0);
        chk("rst_wave_duty", {46'd0, wave, duty_cycle}, 64'd0);
        rst_n = 1'b1;
        step();

        // Two-step program, no loop
        wr(0, F1000, WAVE_SINE, 16'h4000, 16'd3);
        wr(1, F2000, WAVE_SQUARE, 16'h8000, 16'd2);
        wr(2, 64'd0, WAVE_SINE, 16'h0000, 16'd0);
        loop = 1'b0;
        pulse_start();
        chk("load_enable_low", 64'(enable), 64'd0);
        chk("load_busy", 64'(busy), 64'd1);
        step();
        chk("play_enable", 64'(enable), 64'd1);
        chk("play_wave0", 64'(wave), 64'(WAVE_SINE));
        n = 0;
        en_lo = 0;
        while (frequency === F1000 && n < 40) begin
            if (!enable) en_lo++;
            n++;
            step();
        end
        chk("f1000_cycles", 64'(n), 64'd13);
        chk("step1_wave", 64'(wave), 64'(WAVE_SQUARE));
        chk("step1_duty", 64'(duty_cycle), 64'h8000);
        chk("step1_idx", 64'(step_idx), 64'd1);
        n = 0;
        while (frequency === F2000 && n < 40) begin
            if (!enable) en_lo++;
            n++;
            step();
        end
        chk("f2000_cycles", 64'(n), 64'd9);
        chk("enable_held", 64'(en_lo), 64'd0);
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_enable", 64'(enable), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
        step();
        chk("done_one_cycle", 64'(done), 64'd0);
        step();

        // Looping program, then stop
        loop = 1'b1;
        pulse_start();
        nseq = 1;
        seq[0] = step_idx;
        last_idx = step_idx;
        done_cnt = 0;
        en_lo = 0;
        step();
        for (int c = 0; c < 70; c++) begin
            if (done) done_cnt++;
            if (!enable) en_lo++;
            if (step_idx !== last_idx) begin
                if (nseq < 8) seq[nseq] = step_idx;
                nseq++;
                last_idx = step_idx;
            end
            step();
        end
        chk("loop_seq_len", 64'(nseq >= 6), 64'd1);
        chk("loop_seq", {40'd0, seq[0], seq[1], seq[2], seq[3], seq[4], seq[5], 6'd0},
            {40'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 6'd0});
        chk("loop_no_done", 64'(done_cnt), 64'd0);
        chk("loop_enable_held", 64'(en_lo), 64'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_enable", 64'(enable), 64'd0);
        chk("stop_done", 64'(done), 64'd0);
        step();
        chk("stop_stays_idle", 64'(busy), 64'd0);
        loop = 1'b0;

        // All eight entries len 1
        for (int i = 0; i < 8; i++) wr(i, 64'(i + 1) << 32, WAVE_SAWTOOTH, 16'(i), 16'd1);
        pulse_start();
        n = 0;
        k = 0;
        while (!done && k < 200) begin
            if (busy) n++;
            k++;
            step();
        end
        chk("all8_busy_cycles", 64'(n), 64'd40);
        chk("all8_done", 64'(done), 64'd1);
        chk("all8_last_idx", 64'(step_idx), 64'd7);
        chk("all8_last_freq", frequency, 64'd8 << 32);
        step();

        // Empty program with loop set must still finish
        wr(0, F1000, WAVE_SINE, 16'h0000, 16'd0);
        loop = 1'b1;
        pulse_start();
        chk("empty_load_busy", 64'(busy), 64'd1);
        step();
        chk("empty_done", 64'(done), 64'd1);
        chk("empty_enable", 64'(enable), 64'd0);
        loop = 1'b0;
        step();

        // Writes during a run: same-cycle LOAD sees the old entry, later step sees new one
        wr(0, F1000, WAVE_SINE, 16'h4000, 16'd3);
        wr(1, F2000, WAVE_SQUARE, 16'h8000, 16'd2);
        wr(2, 64'd0, WAVE_SINE, 16'h0000, 16'd0);
        pulse_start();
        wr(0, F5000, WAVE_SAWTOOTH, 16'h0001, 16'd3);
        chk("load_old_entry", frequency, F1000);
        step();
        step();
        step();
        wr(1, F3000, WAVE_TRIANGLE, 16'h1234, 16'd1);
        k = 0;
        while (step_idx !== 3'd1 && k < 40) begin
            k++;
            step();
        end
        step();
        chk("new_entry_freq", frequency, F3000);
        chk("new_entry_wave_duty", {46'd0, wave, duty_cycle}, {46'd0, WAVE_TRIANGLE, 16'h1234});
        k = 0;
        while (!done && k < 40) begin
            k++;
            step();
        end
        chk("new_entry_done", 64'(done), 64'd1);
        step();
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("start_stop_busy", 64'(busy), 64'd0);
        step();
        chk("start_stop_idle", 64'(busy | enable), 64'd0);

        // Asynchronous reset mid-PLAY
        wr(0, F1000, WAVE_SINE, 16'h4000, 16'd3);
        pulse_start();
        step();
        step();
        chk("pre_reset_enable", 64'(enable), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_enable", 64'(enable), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_freq", frequency, 64'd0);
        #1 rst_n = 1'b1;
        step();
        wr(0, F1000, WAVE_SINE, 16'h4000, 16'd3);
        wr(1, F2000, WAVE_SQUARE, 16'h8000, 16'd2);
        wr(2, 64'd0, WAVE_SINE, 16'h0000, 16'd0);
        pulse_start();
        chk("replay_idx", 64'(step_idx), 64'd0);
        step();
        chk("replay_freq", frequency, F1000);
        chk("replay_enable", 64'(enable), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
